// File: rtl/isa_pkg.sv
// Opcode spaces, macro op encoding and encoder state shared by the macro encoder slice.
package isa_pkg;

  // Non-prep opcode space
  localparam logic [2:0] OP_PREP = 3'b000;
  localparam logic [2:0] OP_INC  = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_XORR = 3'b011;
  localparam logic [2:0] OP_SLL  = 3'b100;
  localparam logic [2:0] OP_SRL  = 3'b101;

  // Prep opcode space, valid while the decoder is in prep mode
  localparam logic [2:0] OP_ANDI = 3'b000;
  localparam logic [2:0] OP_BEQ  = 3'b001;
  localparam logic [2:0] OP_LW   = 3'b010;
  localparam logic [2:0] OP_SW   = 3'b011;
  localparam logic [2:0] OP_SAVE = 3'b100;
  localparam logic [2:0] OP_PSFT = 3'b101;

  typedef enum logic [3:0] {
    M_INC  = 4'd0,
    M_DEC  = 4'd1,
    M_XOR  = 4'd2,
    M_XORR = 4'd3,
    M_SLL  = 4'd4,
    M_SRL  = 4'd5,
    M_ANDI = 4'd6,
    M_BEQ  = 4'd7,
    M_LW   = 4'd8,
    M_SW   = 4'd9,
    M_SAVE = 4'd10
  } macro_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SINGLE,
    S_PREP,
    S_PSFT,
    S_FINAL
  } enc_state_e;

  function automatic logic isImmOp(input logic [3:0] op);
    return (op >= M_ANDI) && (op <= M_SAVE);
  endfunction

  function automatic logic isIllegalOp(input logic [3:0] op);
    return op > M_SAVE;
  endfunction

  // INC and DEC share an opcode; bit0 tells the decoder which direction
  function automatic logic [8:0] plainWord(input macro_op_e op, input logic [2:0] ra,
                                           input logic [2:0] rb);
    logic [8:0] w;
    w = '0;
    case (op)
      M_INC:   w = {OP_INC, ra, 3'b001};
      M_DEC:   w = {OP_INC, ra, 3'b000};
      M_XOR:   w = {OP_XOR, ra, rb};
      M_XORR:  w = {OP_XORR, ra, 3'b000};
      M_SLL:   w = {OP_SLL, ra, rb};
      M_SRL:   w = {OP_SRL, ra, rb};
      default: w = '0;
    endcase
    return w;
  endfunction

  function automatic logic [2:0] prefixedOpcode(input macro_op_e op);
    logic [2:0] o;
    o = OP_ANDI;
    case (op)
      M_BEQ:   o = OP_BEQ;
      M_LW:    o = OP_LW;
      M_SW:    o = OP_SW;
      M_SAVE:  o = OP_SAVE;
      default: o = OP_ANDI;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/imm_chunk_msb.sv
// Finds the index of the most significant nonzero 6-bit chunk of an immediate (0 when imm is 0).
module imm_chunk_msb #(
  parameter int IMM_W  = 12,
  parameter int NCHUNK = 2,
  parameter int KW     = 2
) (
  input  logic [IMM_W-1:0] imm,
  output logic [KW-1:0]    k
);

  logic [6*NCHUNK-1:0] immExt;

  always_comb begin
    immExt = '0;
    immExt[IMM_W-1:0] = imm;
    k = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (immExt[6*i +: 6] != 6'd0) k = KW'(i);
    end
  end

endmodule

// File: rtl/macro_op_encoder.sv
// Expands one macro-instruction into the 9-bit decoder word stream (PREP, PSFT..., final op)
// and tracks a shadow copy of the decoder's prep mode.
module macro_op_encoder
  import isa_pkg::*;
#(
  parameter int IMM_W   = 12,
  parameter int INSTR_W = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         in_op,
  input  logic [2:0]         in_ra,
  input  logic [2:0]         in_rb,
  input  logic [IMM_W-1:0]   in_imm,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic               out_last,
  output logic               prep_mode,
  output logic               err
);

  localparam int NCHUNK = (IMM_W + 5) / 6;
  localparam int IDX_W  = $clog2(NCHUNK + 1);
  localparam int EXT_W  = 6 * NCHUNK;

  enc_state_e       state, nextState;
  logic [IDX_W-1:0] idx, nextIdx, kAtAccept;
  macro_op_e        opReg;
  logic [2:0]       raReg, rbReg;
  logic [EXT_W-1:0] immReg;
  logic [5:0]       chunk;
  logic             accept, fire;

  assign accept = in_valid && in_ready;
  assign fire   = out_valid && out_ready;

  imm_chunk_msb #(
    .IMM_W (IMM_W),
    .NCHUNK(NCHUNK),
    .KW    (IDX_W)
  ) uChunkMsb (
    .imm(in_imm),
    .k  (kAtAccept)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      idx   <= '0;
    end else begin
      state <= nextState;
      idx   <= nextIdx;
    end
  end

  // Macro fields are only captured for legal ops; prep shadow follows accepted prefixed words
  always_ff @(posedge clk) begin
    if (reset) begin
      opReg     <= M_INC;
      raReg     <= '0;
      rbReg     <= '0;
      immReg    <= '0;
      prep_mode <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= accept && isIllegalOp(in_op);
      if (accept && !isIllegalOp(in_op)) begin
        opReg  <= macro_op_e'(in_op);
        raReg  <= in_ra;
        rbReg  <= in_rb;
        immReg <= EXT_W'(in_imm);
      end
      if (fire) begin
        case (state)
          S_PREP:  prep_mode <= 1'b1;
          S_FINAL: prep_mode <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    nextState = state;
    nextIdx   = idx;
    case (state)
      S_IDLE: begin
        if (accept && !isIllegalOp(in_op)) begin
          if (isImmOp(in_op)) begin
            nextState = S_PREP;
            nextIdx   = kAtAccept;
          end else begin
            nextState = S_SINGLE;
          end
        end
      end
      S_SINGLE: if (fire) nextState = S_IDLE;
      S_PREP, S_PSFT: begin
        if (fire) begin
          if (idx != '0) begin
            nextState = S_PSFT;
            nextIdx   = idx - IDX_W'(1);
          end else begin
            nextState = S_FINAL;
          end
        end
      end
      S_FINAL: if (fire) nextState = S_IDLE;
      default: nextState = S_IDLE;
    endcase
  end

  always_comb begin
    chunk = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx == IDX_W'(i)) chunk = immReg[6*i +: 6];
    end
  end

  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state != S_IDLE);
    out_instr = '0;
    out_last  = 1'b0;
    case (state)
      S_SINGLE: begin
        out_instr = INSTR_W'(plainWord(opReg, raReg, rbReg));
        out_last  = 1'b1;
      end
      S_PREP:  out_instr = INSTR_W'({OP_PREP, chunk});
      S_PSFT:  out_instr = INSTR_W'({OP_PSFT, chunk});
      S_FINAL: begin
        out_instr = INSTR_W'({prefixedOpcode(opReg), raReg, 3'b000});
        out_last  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_macro_op_encoder.sv
// Directed, table-driven bench for macro_op_encoder with hand-written stall, reset and illegal-op sequences.
module tb_macro_op_encoder;
  import isa_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [3:0]  in_op = '0;
  logic [2:0]  in_ra = '0;
  logic [2:0]  in_rb = '0;
  logic [11:0] in_imm = '0;
  logic        in_ready, out_valid, out_last, prep_mode, err;
  logic [8:0]  out_instr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]      op;
    logic [2:0]      ra;
    logic [2:0]      rb;
    logic [11:0]     imm;
    int              n;
    logic [2:0][8:0] w;
  } vec_t;

  vec_t vecs[11];

  macro_op_encoder #(.IMM_W(12), .INSTR_W(9)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_op    (in_op),
    .in_ra    (in_ra),
    .in_rb    (in_rb),
    .in_imm   (in_imm),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_instr(out_instr),
    .out_last (out_last),
    .prep_mode(prep_mode),
    .err      (err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic setVec(input int i, input logic [3:0] op, input logic [2:0] ra,
                        input logic [2:0] rb, input logic [11:0] imm, input int n,
                        input logic [8:0] w0, input logic [8:0] w1, input logic [8:0] w2);
    vecs[i].op   = op;
    vecs[i].ra   = ra;
    vecs[i].rb   = rb;
    vecs[i].imm  = imm;
    vecs[i].n    = n;
    vecs[i].w[0] = w0;
    vecs[i].w[1] = w1;
    vecs[i].w[2] = w2;
  endtask

  // Presents one macro for a single cycle once in_ready is seen; returns at the negedge after accept
  task automatic applyStimulus(input logic [3:0] op, input logic [2:0] ra, input logic [2:0] rb,
                               input logic [11:0] imm);
    @(negedge clk);
    for (int t = 0; t < 20 && !in_ready; t++) @(negedge clk);
    checkOutput("in_ready before accept", 9'(in_ready), 9'd1);
    in_valid = 1'b1;
    in_op    = op;
    in_ra    = ra;
    in_rb    = rb;
    in_imm   = imm;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic collectWords(input int v, input int stall);
    for (int j = 0; j < vecs[v].n; j++) begin
      logic [8:0] expW;
      logic       expPrep;
      expW    = vecs[v].w[j];
      expPrep = (vecs[v].n > 1) && (j < vecs[v].n - 1);
      checkOutput($sformatf("v%0d w%0d valid", v, j), 9'(out_valid), 9'd1);
      checkOutput($sformatf("v%0d w%0d instr", v, j), out_instr, expW);
      checkOutput($sformatf("v%0d w%0d last", v, j), 9'(out_last), (j == vecs[v].n - 1) ? 9'd1 : 9'd0);
      for (int s = 0; s < stall; s++) begin
        out_ready = 1'b0;
        @(negedge clk);
        checkOutput($sformatf("v%0d w%0d stall%0d valid", v, j, s), 9'(out_valid), 9'd1);
        checkOutput($sformatf("v%0d w%0d stall%0d instr", v, j, s), out_instr, expW);
        checkOutput($sformatf("v%0d w%0d stall%0d in_ready", v, j, s), 9'(in_ready), 9'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checkOutput($sformatf("v%0d w%0d prep_mode", v, j), 9'(prep_mode), 9'(expPrep));
    end
    checkOutput($sformatf("v%0d done out_valid", v), 9'(out_valid), 9'd0);
    checkOutput($sformatf("v%0d done in_ready", v), 9'(in_ready), 9'd1);
    checkOutput($sformatf("v%0d done err", v), 9'(err), 9'd0);
  endtask

  task automatic runVec(input int v, input int stall);
    applyStimulus(vecs[v].op, vecs[v].ra, vecs[v].rb, vecs[v].imm);
    collectWords(v, stall);
  endtask

  initial begin
    setVec(0,  M_INC,  3'd2, 3'd0, 12'h000, 1, 9'b001_010_001, 9'd0, 9'd0);
    setVec(1,  M_DEC,  3'd7, 3'd5, 12'h000, 1, 9'b001_111_000, 9'd0, 9'd0);
    setVec(2,  M_XOR,  3'd3, 3'd4, 12'h000, 1, 9'b010_011_100, 9'd0, 9'd0);
    setVec(3,  M_XORR, 3'd6, 3'd5, 12'h000, 1, 9'b011_110_000, 9'd0, 9'd0);
    setVec(4,  M_SLL,  3'd1, 3'd7, 12'h000, 1, 9'b100_001_111, 9'd0, 9'd0);
    setVec(5,  M_SRL,  3'd4, 3'd2, 12'h000, 1, 9'b101_100_010, 9'd0, 9'd0);
    setVec(6,  M_ANDI, 3'd5, 3'd0, 12'h02A, 2, 9'b000_101010, 9'b000_101_000, 9'd0);
    setVec(7,  M_LW,   3'd1, 3'd0, 12'hFC3, 3, 9'b000_111111, 9'b101_000011, 9'b010_001_000);
    setVec(8,  M_BEQ,  3'd0, 3'd0, 12'h000, 2, 9'b000_000000, 9'b001_000_000, 9'd0);
    setVec(9,  M_SAVE, 3'd2, 3'd0, 12'h040, 3, 9'b000_000001, 9'b101_000000, 9'b100_010_000);
    setVec(10, M_SW,   3'd3, 3'd0, 12'h03F, 2, 9'b000_111111, 9'b011_011_000, 9'd0);

    reset = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset in_ready", 9'(in_ready), 9'd1);
    checkOutput("reset out_valid", 9'(out_valid), 9'd0);
    checkOutput("reset out_instr", out_instr, 9'd0);
    checkOutput("reset out_last", 9'(out_last), 9'd0);
    checkOutput("reset prep_mode", 9'(prep_mode), 9'd0);
    checkOutput("reset err", 9'(err), 9'd0);
    reset = 1'b0;

    for (int v = 0; v < 11; v++) runVec(v, 0);

    runVec(7, 5);

    // Reset lands while the final SW word is pending
    applyStimulus(M_SW, 3'd3, 3'd0, 12'h7C1);
    checkOutput("rst seq prep word", out_instr, 9'b000_011111);
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("rst seq psft word", out_instr, 9'b101_000001);
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("rst seq final word", out_instr, 9'b011_011_000);
    checkOutput("rst seq prep before", 9'(prep_mode), 9'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("rst seq out_valid", 9'(out_valid), 9'd0);
    checkOutput("rst seq prep_mode", 9'(prep_mode), 9'd0);
    checkOutput("rst seq in_ready", 9'(in_ready), 9'd1);
    checkOutput("rst seq out_instr", out_instr, 9'd0);

    applyStimulus(4'hF, 3'd1, 3'd1, 12'h000);
    checkOutput("illegal err pulse", 9'(err), 9'd1);
    checkOutput("illegal out_valid", 9'(out_valid), 9'd0);
    @(negedge clk);
    checkOutput("illegal err clears", 9'(err), 9'd0);
    checkOutput("illegal out_valid later", 9'(out_valid), 9'd0);
    checkOutput("illegal in_ready", 9'(in_ready), 9'd1);
    runVec(2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
